// File: rtl/render_sched_if.sv
// Framebuffer write-port and pass handshake bundle for render_sched.
// master: the sequencer; slave: the map renderer / overlay / framebuffer side.
interface render_sched_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16
);
  logic              render_start;
  logic              render_done;
  logic [ADDR_W-1:0] map_addr;
  logic [DATA_W-1:0] map_data;
  logic              map_wr;
  logic              ovl_start;
  logic              ovl_done;
  logic [ADDR_W-1:0] ovl_addr;
  logic [DATA_W-1:0] ovl_data;
  logic              ovl_wr;
  logic [ADDR_W-1:0] dst_addr;
  logic [DATA_W-1:0] dst_data;
  logic              dst_wr;

  modport master (
    output render_start, ovl_start,
    output dst_addr, dst_data, dst_wr,
    input  render_done, ovl_done,
    input  map_addr, map_data, map_wr,
    input  ovl_addr, ovl_data, ovl_wr
  );

  modport slave (
    input  render_start, ovl_start,
    input  dst_addr, dst_data, dst_wr,
    output render_done, ovl_done,
    output map_addr, map_data, map_wr,
    output ovl_addr, ovl_data, ovl_wr
  );
endinterface

// File: rtl/render_sched.sv
// Frame sequencer: detects stale screen, snapshots scene, runs map then
// overlay pass, muxes the framebuffer port. Ports: clk/rst, scene inputs,
// snap_* outputs, status (busy/frame_done/timeout_err/frame_count), bus.
module render_sched #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int OVERLAY_EN = 1,
  parameter int TIMEOUT    = 1048575,
  parameter int TO_W       = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] map_id,
  input  logic [3:0]  player_x,
  input  logic [3:0]  player_y,
  input  logic        anim_tick,
  input  logic        force_redraw,
  output logic [18:0] snap_map_id,
  output logic [3:0]  snap_player_x,
  output logic [3:0]  snap_player_y,
  output logic        snap_swap,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err,
  output logic [15:0] frame_count,
  render_sched_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, MAP, OVL, FIN
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, state_n;
  logic            dirty, anim_pend;
  logic [TO_W-1:0] cnt;
  logic            launch, to_hit;
  logic            mismatch, ev;

  assign mismatch = (map_id != snap_map_id)
                  | (player_x != snap_player_x)
                  | (player_y != snap_player_y);
  assign ev   = anim_tick | force_redraw;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    launch  = 1'b0;
    to_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (dirty) begin
          state_n = MAP;
          launch  = 1'b1;
        end
      end
      MAP: begin
        if (bus.render_done) begin
          state_n = (OVERLAY_EN != 0) ? OVL : FIN;
        end else if (cnt == TO_LAST) begin
          state_n = IDLE;
          to_hit  = 1'b1;
        end
      end
      OVL: begin
        if (bus.ovl_done) begin
          state_n = FIN;
        end else if (cnt == TO_LAST) begin
          state_n = IDLE;
          to_hit  = 1'b1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_map_id      <= '0;
      snap_player_x    <= '0;
      snap_player_y    <= '0;
      snap_swap        <= 1'b0;
      dirty            <= 1'b1;
      anim_pend        <= 1'b0;
      cnt              <= '0;
      bus.render_start <= 1'b0;
      bus.ovl_start    <= 1'b0;
      bus.dst_addr     <= '0;
      bus.dst_data     <= '0;
      bus.dst_wr       <= 1'b0;
      frame_done       <= 1'b0;
      timeout_err      <= 1'b0;
      frame_count      <= '0;
    end else begin
      // On launch the mismatch terms vanish (snap takes the inputs), so
      // only same-cycle pulses can re-arm the next frame.
      if (launch) begin
        snap_map_id   <= map_id;
        snap_player_x <= player_x;
        snap_player_y <= player_y;
        snap_swap     <= snap_swap ^ anim_pend;
        dirty         <= ev;
        anim_pend     <= anim_tick;
      end else begin
        dirty     <= dirty | mismatch | ev | to_hit;
        anim_pend <= anim_pend | anim_tick;
      end

      if (state_n != state)
        cnt <= '0;
      else if (state == MAP || state == OVL)
        cnt <= cnt + 1'b1;

      bus.render_start <= launch;
      bus.ovl_start    <= (state == MAP) && (state_n == OVL);
      frame_done       <= (state_n == FIN);

      if (state == FIN) frame_count <= frame_count + 16'd1;
      if (to_hit)       timeout_err <= 1'b1;

      if (state == MAP) begin
        bus.dst_addr <= bus.map_addr;
        bus.dst_data <= bus.map_data;
        bus.dst_wr   <= bus.map_wr;
      end else if (state == OVL) begin
        bus.dst_addr <= bus.ovl_addr;
        bus.dst_data <= bus.ovl_data;
        bus.dst_wr   <= bus.ovl_wr;
      end else begin
        bus.dst_wr   <= 1'b0;
      end
    end
  end

endmodule
